spi_cmd_decoder: RTL
====================

// Module: spi_cmd_decoder
// PURPOSE
//  Downstream of the SPI 8-bit front end; turns its received byte stream into register-bank
//  accesses and returns read data for the front end to shift out on miso.
//  Frame = slave-select low: one command byte, then burst data bytes, address auto-incrementing.
//  Command byte: bit7 = 1 write / 0 read; bits[ADDR_W-1:0] = start address.
//  Drives the register_bank wr/address/data_in port and samples its data_out.
// PARAMETERS
//  DATA_W      8  byte width; fixed at 8, bit7 of the command byte is R/W
//  ADDR_W      7  register address width, 1..7
//  RD_LATENCY  1  cycles from reg_rd high to reg_rdata valid, 1..3
// PORTS
//  clk        in   1       system clock
//  rst        in   1       reset, asynchronous, active-low
//  ss         in   1       SPI slave select from pad, active low, asynchronous to clk
//  rx_data    in   DATA_W  byte from front end (data_out)
//  rx_valid   in   1       one-cycle pulse, rx_data valid (data_out_valid)
//  tx_data    out  DATA_W  byte for front end to transmit (data_in)
//  tx_load    out  1       one-cycle pulse, tx_data updated this cycle
//  reg_wr     out  1       register write strobe, one cycle
//  reg_rd     out  1       register read strobe, one cycle
//  reg_addr   out  ADDR_W  register address
//  reg_wdata  out  DATA_W  register write data
//  reg_rdata  in   DATA_W  register read data
//  busy       out  1       1 while state != IDLE
//  overrun    out  1       sticky: byte arrived while read in flight; cleared on entering IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, all outputs 0, ss synchroniser flops = 1.
//  ss passes a 2-FF synchroniser -> ss_s. Frame active while ss_s==0.
//  All outputs registered. States: IDLE, CMD, WDATA, RDREQ, RDWAIT, RDNEXT.
//  ss_s==1 in any state -> IDLE next cycle: no strobes, overrun<=0, in-flight read dropped
//    (no tx_load). Wins over a simultaneous rx_valid; that byte is discarded.
//  IDLE: ss_s==0 -> CMD.
//  CMD: rx_valid at cycle n -> reg_addr<=rx_data[ADDR_W-1:0] (valid n+1);
//    rx_data[7]=1 -> WDATA; rx_data[7]=0 -> RDREQ.
//  WDATA: rx_valid at cycle n -> reg_wr=1, reg_wdata=rx_data, reg_addr=A in cycle n+1;
//    reg_addr=A+1 from cycle n+2. Remain in WDATA.
//  RDREQ: reg_rd=1 for exactly one cycle t at current reg_addr; -> RDWAIT.
//  RDWAIT: count RD_LATENCY cycles. reg_rdata sampled at the end of cycle t+RD_LATENCY;
//    tx_data=sample and tx_load=1 in cycle t+RD_LATENCY+1. reg_addr+1 in that cycle. -> RDNEXT.
//  RDNEXT: rx_valid (dummy byte, content ignored) -> RDREQ (prefetch next address).
//  rx_valid in RDREQ/RDWAIT: byte ignored, overrun<=1; read completes normally.
//  Address increment wraps modulo 2^ADDR_W (e.g. 7'h7F -> 7'h00), in both write and read.
//  reg_wr and reg_rd never high in the same cycle. tx_data holds its value until the next tx_load.
//  Read byte 0 is loaded before the first dummy byte. The front end shifts it out
//    during that byte.
// TESTING
//  1 Write burst: ss low, bytes 8'h85,8'hAA,8'h55 -> reg_wr at addr 5 data AA, addr 6 data 55,
//    each one cycle after rx_valid; no reg_rd.
//  2 Read burst: cmd 8'h10, RD_LATENCY=1, regs[16]=8'h3C, regs[17]=8'hC3 -> reg_rd@16,
//    tx_load with 3C two cycles later; dummy byte -> reg_rd@17, tx_load C3.
//  3 Wrap: cmd 8'hFF then data 8'h01,8'h02 -> writes addr 7F=01, addr 00=02.
//  4 Overrun: cmd 8'h02, rx_valid pulsed during RDWAIT (RD_LATENCY=3) -> overrun=1, read still
//    completes; ss high -> busy=0, overrun=0 within 3 cycles.
//  5 ss deassert mid-read, same cycle as rx_valid -> no tx_load, no further strobes,
//    state IDLE; next frame cmd decoded fresh.
//  6 rst low mid-write-burst (asynchronous to clk edge) -> all outputs 0 immediately;
//    after release with ss high -> busy=0.

Source files
------------

// File: rtl/spi_cmd_decoder_if.sv
// Bundle of the byte-stream and register-bank signals around spi_cmd_decoder.
//   master : the decoder side (takes received bytes and register read data,
//            drives transmit bytes, register strobes, address and write data,
//            and the busy/overrun status)
//   slave  : the environment side (SPI front end plus register bank)
// Signals:
//   rx_data/rx_valid   byte from the front end and its one-cycle valid pulse
//   tx_data/tx_load    byte for the front end to shift out and its load pulse
//   reg_wr/reg_rd      one-cycle register write / read strobes
//   reg_addr/reg_wdata register address and write data
//   reg_rdata          register read data
//   busy/overrun       frame-in-progress flag and sticky overrun flag
interface spi_cmd_decoder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              reg_wr;
  logic              reg_rd;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              busy;
  logic              overrun;

  modport master (
    input  rx_data, rx_valid, reg_rdata,
    output tx_data, tx_load, reg_wr, reg_rd, reg_addr, reg_wdata, busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, reg_rdata,
    input  tx_data, tx_load, reg_wr, reg_rd, reg_addr, reg_wdata, busy, overrun
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Turns the byte stream of an 8-bit SPI front end into register-bank accesses.
// A frame is slave-select low: one command byte (bit7 = write, low bits = start
// address) followed by a burst of data bytes with an auto-incrementing address.
// On reads, each byte is prefetched so it is loaded into the front end before
// the dummy byte that shifts it out arrives.
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   ss     SPI slave select from the pad, active low, asynchronous to clk
//   bus    spi_cmd_decoder_if.master (byte stream, register port, status)
module spi_cmd_decoder #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 7,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ss,
  spi_cmd_decoder_if.master       bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] WDATA  = 3'd2;
  localparam logic [2:0] RDREQ  = 3'd3;
  localparam logic [2:0] RDWAIT = 3'd4;
  localparam logic [2:0] RDNEXT = 3'd5;

  // Last value of the wait counter: it reads 0 in cycle t+1 after the strobe,
  // so it reaches this value in cycle t+RD_LATENCY, when reg_rdata is valid.
  localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

  logic              ss_meta_q, ss_s_q;
  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              tx_load_q, tx_load_d;
  logic              overrun_q, overrun_d;
  logic              busy_q;

  // Two-flop synchroniser; resets to the inactive (high) level so no frame
  // appears to start while reset is released.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_meta_q <= 1'b1;
      ss_s_q    <= 1'b1;
    end else begin
      ss_meta_q <= ss;
      ss_s_q    <= ss_meta_q;
    end
  end

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    tx_data_d   = tx_data_q;
    overrun_d   = overrun_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    tx_load_d   = 1'b0;

    if (state_q != IDLE && ss_s_q) begin
      // Frame ended: abandon everything, including a read in flight and any
      // byte arriving this cycle.
      state_d   = IDLE;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          overrun_d = 1'b0;
          if (!ss_s_q) state_d = CMD;
        end
        CMD: begin
          if (bus.rx_valid) begin
            reg_addr_d = bus.rx_data[ADDR_W-1:0];
            if (bus.rx_data[7]) begin
              state_d = WDATA;
            end else begin
              state_d  = RDREQ;
              reg_rd_d = 1'b1;
            end
          end
        end
        WDATA: begin
          // The address steps one cycle after each strobe, so the strobe cycle
          // still presents the address being written, even for back-to-back bytes.
          if (reg_wr_q) reg_addr_d = reg_addr_q + 1'b1;
          if (bus.rx_valid) begin
            reg_wr_d    = 1'b1;
            reg_wdata_d = bus.rx_data;
          end
        end
        RDREQ: begin
          // reg_rd was raised on entry, so it lasts exactly this one cycle.
          state_d = RDWAIT;
          cnt_d   = 2'd0;
          if (bus.rx_valid) overrun_d = 1'b1;
        end
        RDWAIT: begin
          if (bus.rx_valid) overrun_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            tx_data_d  = bus.reg_rdata;
            tx_load_d  = 1'b1;
            reg_addr_d = reg_addr_q + 1'b1;
            state_d    = RDNEXT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RDNEXT: begin
          // Dummy byte: its content is irrelevant, it only paces the prefetch.
          if (bus.rx_valid) begin
            state_d  = RDREQ;
            reg_rd_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      tx_data_q   <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      tx_load_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      tx_data_q   <= tx_data_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      tx_load_q   <= tx_load_d;
      overrun_q   <= overrun_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_load   = tx_load_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule
